// File: rtl/riscv_multicycle_controller.sv
// riscv_multicycle_controller: Moore sequencer driving the shared-ALU multicycle RISC-V datapath.
// Defining MEM_READY_EN adds a mem_ready handshake that stalls FETCH, MEMREAD and MEMWRITE.
module riscv_multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  input  logic               Menor,
`ifdef MEM_READY_EN
  input  logic               mem_ready,
`endif
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [2:0]         ALUControl,
  output logic               Illegal,
  output logic [STATE_W-1:0] state
);
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR = 7'b1100011;
  typedef enum logic [STATE_W-1:0] {
    FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5,
    EXECUTER = 6, ALUWB = 7, EXECUTEI = 8, JAL = 9, BRANCH = 10
  } st_t;
  typedef struct packed {
    logic       adr;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic       pcw;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       br;
    logic       fetch;
  } ctl_t;
  st_t        st, nxt;
  ctl_t       r;
  logic       ready, taken, legal;
  logic [2:0] funct_alu;
`ifdef MEM_READY_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif
  assign funct_alu = funct3 == 3'b000 ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                     funct3 == 3'b010 ? 3'b101 :
                     funct3 == 3'b110 ? 3'b011 :
                     funct3 == 3'b111 ? 3'b010 : 3'b000;
  assign taken = funct3 == 3'b000 ? Zero :
                 funct3 == 3'b001 ? ~Zero :
                 funct3 == 3'b100 ? Menor :
                 funct3 == 3'b101 ? (~Menor | Zero) : 1'b0;
  assign legal = op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR};
  // Control word of the state about to be entered, so outputs come straight from flops
  function automatic ctl_t dec(input st_t s, input logic [2:0] fa);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.irw = 1'b1; c.pcw = 1'b1; c.fetch = 1'b1; c.srcb = 2'b10; c.res = 2'b10; end
      DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
      MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
      MEMREAD:  c.adr = 1'b1;
      MEMWB:    begin c.res = 2'b01; c.rw = 1'b1; end
      MEMWRITE: begin c.adr = 1'b1; c.mw = 1'b1; end
      EXECUTER: begin c.srca = 2'b10; c.alu = fa; end
      EXECUTEI: begin c.srca = 2'b10; c.srcb = 2'b01; c.alu = fa; end
      ALUWB:    c.rw = 1'b1;
      JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcw = 1'b1; end
      BRANCH:   begin c.srca = 2'b10; c.alu = 3'b001; c.br = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:    nxt = ready ? DECODE : FETCH;
      DECODE:   nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                      op == OP_R ? EXECUTER :
                      op == OP_I ? EXECUTEI :
                      op == OP_JAL ? JAL :
                      op == OP_BR ? BRANCH : FETCH;
      MEMADR:   nxt = op == OP_SW ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = ready ? MEMWB : MEMREAD;
      MEMWRITE: nxt = ready ? FETCH : MEMWRITE;
      EXECUTER, EXECUTEI, JAL: nxt = ALUWB;
      default:  nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    st <= reset ? FETCH : nxt;
    r <= dec(reset ? FETCH : nxt, funct_alu);
  end
  // While reset is held every output shows the FETCH decode with all write enables off
  assign PCWrite = ~reset & ((r.pcw & (~r.fetch | ready)) | (r.br & taken));
  assign IRWrite = ~reset & r.irw & ready;
  assign MemWrite = ~reset & r.mw;
  assign RegWrite = ~reset & r.rw;
  assign AdrSrc = ~reset & r.adr;
  assign ResultSrc = reset ? 2'b10 : r.res;
  assign ALUSrcA = reset ? 2'b00 : r.srca;
  assign ALUSrcB = reset ? 2'b10 : r.srcb;
  assign ALUControl = reset ? 3'b000 : r.alu;
  assign Illegal = ~reset & (st == DECODE) & ~legal;
  assign ImmSrc = op == OP_SW ? 2'b01 : op == OP_BR ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
  assign state = st;
endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// tb_riscv_multicycle_controller: directed and random instruction streams checked against a state-sequence model.
module tb_riscv_multicycle_controller;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, Zero = 1'b0, Menor = 1'b0, mem_ready = 1'b1;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic [16:0] outs;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  riscv_multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Menor(Menor),
`ifdef MEM_READY_EN
    .mem_ready(mem_ready),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .ALUControl(ALUControl), .Illegal(Illegal), .state(state)
  );
  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ImmSrc, RegWrite, ALUControl, Illegal};
  // Spec output table, evaluated from the current inputs for a given state number
  function automatic logic [16:0] model(input logic [3:0] s);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, imm;
    logic [2:0] alu = 0, fa;
    logic tk;
    fa = 3'b000;
    if (funct3 == 3'b000 && op[5] && funct7b5) fa = 3'b001;
    if (funct3 == 3'b010) fa = 3'b101;
    if (funct3 == 3'b110) fa = 3'b011;
    if (funct3 == 3'b111) fa = 3'b010;
    tk = (funct3 == 3'b000 && Zero) || (funct3 == 3'b001 && !Zero) ||
         (funct3 == 3'b100 && Menor) || (funct3 == 3'b101 && (!Menor || Zero));
    imm = (op == SW) ? 2'b01 : (op == BR) ? 2'b10 : (op == JL) ? 2'b11 : 2'b00;
    case (s)
      0: begin irw = mem_ready; pcw = mem_ready; sb = 2; rs = 2; end
      1: begin sa = 1; sb = 1; ill = !(op inside {LW, SW, RT, IT, JL, BR}); end
      2: begin sa = 2; sb = 1; end
      3: adr = 1;
      4: begin rs = 1; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: begin sa = 2; alu = fa; end
      7: rw = 1;
      8: begin sa = 2; sb = 1; alu = fa; end
      9: begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; alu = 3'b001; pcw = tk; end
      default: ;
    endcase
    if (reset) begin pcw = 0; mw = 0; irw = 0; rw = 0; end
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, ill};
  endfunction
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input bit rnd, input logic z, input logic m, input string name);
    logic [3:0] seq[$];
    int idx = 0, waits = 0;
    seq.push_back(4'd0);
    seq.push_back(4'd1);
    case (o)
      LW: begin seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd4); end
      SW: begin seq.push_back(4'd2); seq.push_back(4'd5); end
      RT: begin seq.push_back(4'd6); seq.push_back(4'd7); end
      IT: begin seq.push_back(4'd8); seq.push_back(4'd7); end
      JL: begin seq.push_back(4'd9); seq.push_back(4'd7); end
      BR: seq.push_back(4'd10);
      default: ;
    endcase
    op = o; funct3 = f3; funct7b5 = f7;
    while (idx < seq.size()) begin
      if (rnd) begin
        Zero = 1'($urandom); Menor = 1'($urandom);
`ifdef MEM_READY_EN
        mem_ready = (waits >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
`endif
      end else begin
        Zero = z; Menor = m;
      end
      #1;
      total++;
      if (state !== seq[idx]) $display("FAIL %s state: got %0d expected %0d", name, state, seq[idx]);
      else passed++;
      total++;
      if (outs !== model(seq[idx]))
        $display("FAIL %s outputs in state %0d: got %b expected %b", name, seq[idx], outs, model(seq[idx]));
      else passed++;
      if (!(seq[idx] inside {4'd0, 4'd3, 4'd5}) || mem_ready) begin idx++; waits = 0; end
      else waits++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; op = JL;
    repeat (2) begin
      #1;
      total++;
      if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0 || outs !== model(4'd0))
        $display("FAIL reset outputs: got %b expected %b", outs, model(4'd0));
      else passed++;
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || PCWrite !== 1'b1 || IRWrite !== 1'b1)
      $display("FAIL reset release: got state %0d pcw %b irw %b expected 0 1 1", state, PCWrite, IRWrite);
    else passed++;
  endtask
  task automatic test_lw;
    run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, "lw");
  endtask
  task automatic test_alu_decode;
    run_instr(RT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, "sub");
    run_instr(IT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, "addi_f7");
    run_instr(RT, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, "slt");
    run_instr(IT, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, "ori");
    run_instr(RT, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, "and");
  endtask
  task automatic test_branch;
    run_instr(BR, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, "bge_lt");
    run_instr(BR, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, "bge_ge");
    run_instr(BR, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, "bne_eq");
    run_instr(BR, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, "beq_eq");
    run_instr(BR, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "br_bad_f3");
  endtask
  task automatic test_jal;
    run_instr(JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "jal");
  endtask
  task automatic test_illegal;
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "illegal");
    run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "jalr_illegal");
  endtask
  task automatic test_mem_wait;
`ifdef MEM_READY_EN
    op = LW; mem_ready = 1'b0;
    repeat (3) begin
      #1;
      total++;
      if (state !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0)
        $display("FAIL fetch_wait: got state %0d irw %b pcw %b expected 0 0 0", state, IRWrite, PCWrite);
      else passed++;
      @(negedge clk);
    end
    mem_ready = 1'b1;
    run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, "lw_after_wait");
`endif
  endtask
  task automatic test_reset_mid;
    op = SW; funct3 = 3'b010; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (state !== 4'd5 || MemWrite !== 1'b0)
      $display("FAIL reset_mid hold: got state %0d mw %b expected 5 0", state, MemWrite);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (state !== 4'd0 || outs !== model(4'd0))
      $display("FAIL reset_mid fetch: got state %0d outs %b expected 0 %b", state, outs, model(4'd0));
    else passed++;
    reset = 1'b0;
  endtask
  task automatic test_back_to_back;
    logic [6:0] ops[8] = '{LW, SW, RT, IT, JL, BR, 7'b1111111, 7'b0110111};
    for (int i = 0; i < 80; i++)
      run_instr(ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0, "random");
    mem_ready = 1'b1;
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_lw;
    test_alu_decode;
    test_branch;
    test_jal;
    test_illegal;
    test_mem_wait;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
Sequencing controller for the multicycle RISC-V core. It decodes op/funct3/funct7b5 and Zero/Menor from the shared datapath, whose single ALU and unified instruction/data memory are reused across cycles. It drives all datapath selects and write enables from a Moore FSM. Instruction subset: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq/bne/blt/bge, jal.

Parameters:
STATE_W, 4, width of state register and debug state port

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  7  instruction opcode (from IR)
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
Zero  in  1  ALU result == 0
Menor  in  1  ALU signed less-than (rs1 < rs2)
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0=PC, 1=Result
MemWrite  out  1  memory write enable
IRWrite  out  1  IR/OldPC enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=const 4
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
RegWrite  out  1  register file write enable
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
Illegal  out  1  pulse in DECODE for an unsupported opcode
state  out  STATE_W  current state (debug)

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BRANCH 10. Codes 11-15 go to FETCH.
- Reset: on a clk edge with reset=1, state <= FETCH. While reset=1, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0. All other outputs follow the FETCH decode.
- Transitions: FETCH->DECODE.
- DECODE: lw/sw->MEMADR; R->EXECUTER; I-ALU->EXECUTEI; jal->JAL; branch->BRANCH; other opcodes->FETCH with Illegal=1.
- MEMADR: ->MEMREAD for lw, ->MEMWRITE for sw. MEMREAD->MEMWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH. EXECUTER/EXECUTEI/JAL -> ALUWB.
- Outputs per state. Anything not listed is 0 / 00 / add.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (precomputes branch/jal target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, funct decode.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct decode.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=taken.
- taken is combinational from Zero/Menor by funct3: 000 Zero; 001 ~Zero; 100 Menor; 101 ~Menor|Zero; any other funct3 gives 0.
- Funct decode by funct3:
  - 000 -> sub only if op[5] & funct7b5, else add. addi never subtracts.
  - 010 -> slt; 110 -> or; 111 -> and; others -> add.
- ImmSrc is combinational from op in every state: lw/I-ALU 00, sw 01, branch 10, jal 11, else 00.
- Latency (cycles, FETCH inclusive): lw 5, sw 4, R 4, I 4, jal 4, branch 3, illegal 2.
- Only PCWrite in BRANCH depends on datapath status. All other outputs are functions of state/op/funct only.

Optional Feature:
MEM_READY_EN. When defined, the block adds input port mem_ready (1 bit).
- FETCH, MEMREAD and MEMWRITE hold until mem_ready=1.
- IRWrite and PCWrite in FETCH assert only in the cycle with mem_ready=1.
- MemWrite stays high throughout MEMWRITE.
- Reset during a wait returns to FETCH.
When undefined, the port is absent and behaviour is identical to mem_ready tied to 1.

Test Plan:
- reset=1 for 2 cycles, then release -> state=0; PCWrite/IRWrite=1 in the first cycle after release; no RegWrite/MemWrite during reset.
- lw (op 0000011) -> states 0,1,2,3,4; RegWrite=1 and ResultSrc=01 only in state 4; 5 cycles total.
- sub (op 0110011, funct3 000, funct7b5=1) -> ALUControl=001 in EXECUTER. addi with funct7b5=1 -> ALUControl=000.
- bge (funct3 101): Menor=1, Zero=0 -> PCWrite=0 in BRANCH. Menor=0 -> PCWrite=1. bne with Zero=1 -> PCWrite=0.
- jal -> states 0,1,9,7; PCWrite=1 in JAL; RegWrite=1 in ALUWB; ImmSrc=11.
- op 1111111 -> Illegal=1 in DECODE, next state FETCH, no writes. With MEM_READY_EN and mem_ready=0 for 3 cycles in FETCH -> state stays 0, IRWrite=0 until ready.
